probe_register_shifter: RTL and testbench

PROBE_REGISTER_SHIFTER -- requirements
Module: Probe_Register_Shifter

---
 rtl/probe_register_shifter.sv | 170 +++++++++++++++++
 tb/tb_probe_register_shifter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/probe_register_shifter.sv
`default_nettype none
// probe_register_shifter: streams 193 FIFO bytes (1544 probe bits, MSB first) into the ASIC probe chain.
// Optional macro PROBE_SROUT_COUNT_EN adds In_Srout_Probe/Out_Srout_Ones (count of high Srout samples). Rev 1.0
module probe_register_shifter #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RD_TIMEOUT = 4095
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        Start_In,
  input  logic        In_Fifo_Empty,
  input  logic [7:0]  In_Fifo_Dout,
  output logic        Out_Fifo_Rd_En,
  output logic        Out_Clk_Probe,
  output logic        Out_Srin_Probe,
  output logic        Out_Busy,
  output logic        End_Flag,
  output logic        Out_Err_Timeout
`ifdef PROBE_SROUT_COUNT_EN
  ,
  input  logic        In_Srout_Probe,
  output logic [10:0] Out_Srout_Ones
`endif
);

  localparam logic [7:0]  LAST_BYTE = 8'd192;
  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [12:0] TMO_LIMIT = 13'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_REQ     = 3'd1,
    RD_WAIT    = 3'd2,
    LOAD       = 3'd3,
    SHIFT_LOW  = 3'd4,
    SHIFT_HIGH = 3'd5,
    NEXT_BIT   = 3'd6,
    END        = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [11:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
  logic        clk_probe_q, clk_probe_d;
  logic        srin_q, srin_d;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      div_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      clk_probe_q <= 1'b0;
      srin_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= Start_In;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      div_cnt_q   <= div_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      clk_probe_q <= clk_probe_d;
      srin_q      <= srin_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    div_cnt_d      = '0;
    tmo_cnt_d      = tmo_cnt_q;
    err_d          = err_q;
    Out_Fifo_Rd_En = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_In && !start_q) begin
          state_d    = RD_REQ;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end
      RD_REQ: begin
        if (!In_Fifo_Empty) begin
          Out_Fifo_Rd_En = 1'b1;
          tmo_cnt_d      = '0;
          state_d        = RD_WAIT;
        end else if ((13'(tmo_cnt_q) + 13'd1) >= TMO_LIMIT) begin
          // Abort straight to IDLE: no END state, so End_Flag never fires.
          err_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 12'd1;
        end
      end
      RD_WAIT: state_d = LOAD;
      LOAD: begin
        shreg_d   = In_Fifo_Dout;
        bit_cnt_d = '0;
        state_d   = SHIFT_LOW;
      end
      SHIFT_LOW: begin
        if (div_cnt_q == DIV_LAST) state_d = SHIFT_HIGH;
        else                       div_cnt_d = div_cnt_q + 8'd1;
      end
      SHIFT_HIGH: begin
        if (div_cnt_q == DIV_LAST) state_d = NEXT_BIT;
        else                       div_cnt_d = div_cnt_q + 8'd1;
      end
      NEXT_BIT: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        if (bit_cnt_q != 3'd7) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = SHIFT_LOW;
        end else begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          state_d    = (byte_cnt_q == LAST_BYTE) ? END : RD_REQ;
        end
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Probe clock and data are registered from next state so the ASIC pins never glitch.
  always_comb begin
    clk_probe_d = (state_d == SHIFT_HIGH);
    srin_d      = 1'b0;
    if (state_d == SHIFT_LOW || state_d == SHIFT_HIGH) srin_d = shreg_d[7];
  end

  assign Out_Clk_Probe   = clk_probe_q;
  assign Out_Srin_Probe  = srin_q;
  assign Out_Busy        = (state_q != IDLE);
  assign End_Flag        = (state_q == END);
  assign Out_Err_Timeout = err_q;

`ifdef PROBE_SROUT_COUNT_EN
  logic [10:0] ones_q;
  logic        start_acc;
  logic        sample_pt;

  assign start_acc = (state_q == IDLE) && Start_In && !start_q;
  assign sample_pt = (state_q == SHIFT_HIGH) && (div_cnt_q == DIV_LAST);

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N)                          ones_q <= '0;
    else if (start_acc)                  ones_q <= '0;
    else if (sample_pt && In_Srout_Probe) ones_q <= ones_q + 11'd1;
  end

  assign Out_Srout_Ones = ones_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_probe_register_shifter.sv
`default_nettype none
// tb_probe_register_shifter: directed load scenarios with random FIFO data checked against a bit-stream model.
module tb_probe_register_shifter;

  localparam int CLK_DIV    = 2;
  localparam int RD_TIMEOUT = 20;
  localparam int NBYTES     = 193;
  localparam int NBITS      = NBYTES * 8;
  localparam int BUDGET     = 20000;

  logic       Clk = 1'b0;
  logic       Rst_N;
  logic       Start_In;
  logic       In_Fifo_Empty = 1'b1;
  logic [7:0] In_Fifo_Dout  = 8'h00;
  logic       Out_Fifo_Rd_En, Out_Clk_Probe, Out_Srin_Probe, Out_Busy, End_Flag, Out_Err_Timeout;
`ifdef PROBE_SROUT_COUNT_EN
  logic        In_Srout_Probe = 1'b1;
  logic [10:0] Out_Srout_Ones;
`endif

  always #5 Clk = ~Clk;

  probe_register_shifter #(.CLK_DIV(CLK_DIV), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .Clk             (Clk),
    .Rst_N           (Rst_N),
    .Start_In        (Start_In),
    .In_Fifo_Empty   (In_Fifo_Empty),
    .In_Fifo_Dout    (In_Fifo_Dout),
    .Out_Fifo_Rd_En  (Out_Fifo_Rd_En),
    .Out_Clk_Probe   (Out_Clk_Probe),
    .Out_Srin_Probe  (Out_Srin_Probe),
    .Out_Busy        (Out_Busy),
    .End_Flag        (End_Flag),
    .Out_Err_Timeout (Out_Err_Timeout)
`ifdef PROBE_SROUT_COUNT_EN
    ,
    .In_Srout_Probe  (In_Srout_Probe),
    .Out_Srout_Ones  (Out_Srout_Ones)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  bit         rise_bits[$];
  int         rises, reads, end_cnt, end_long;
  logic       prev_clk = 1'b0;
  logic       prev_end = 1'b0;
  bit         rd_acc = 1'b0;

  // Standard-read FIFO: data appears after the edge that accepted the strobe.
  always @(posedge Clk) begin
    #1;
    if (rd_acc) begin
      rd_acc = 1'b0;
      if (fifo_q.size() > 0) begin
        In_Fifo_Dout = fifo_q.pop_front();
        sent_q.push_back(In_Fifo_Dout);
      end
    end
    In_Fifo_Empty = (fifo_q.size() == 0);
  end

  always @(negedge Clk) begin
    rd_acc = Out_Fifo_Rd_En && !In_Fifo_Empty;
    if (rd_acc) reads++;
    if (Out_Clk_Probe && !prev_clk) begin
      rises++;
      rise_bits.push_back(Out_Srin_Probe);
    end
    if (End_Flag) begin
      if (prev_end) end_long++;
      else          end_cnt++;
    end
    prev_clk = Out_Clk_Probe;
    prev_end = End_Flag;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    rises = 0; reads = 0; end_cnt = 0; end_long = 0;
    rise_bits.delete();
    sent_q.delete();
  endtask

  task automatic push_rand(input int n);
    repeat (n) fifo_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_start();
    Start_In = 1'b1;
    step(1);
    Start_In = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (Out_Busy && i < BUDGET) begin
      step(1);
      i++;
    end
    check({tag, "_idle"}, int'(Out_Busy), 0);
  endtask

  task automatic wait_rises(input int target, input string tag);
    int i = 0;
    while (rises < target && i < BUDGET) begin
      step(1);
      i++;
    end
    check({tag, "_reach"}, int'(rises >= target), 1);
  endtask

  // Expected probe stream: every byte the FIFO delivered, MSB first, in delivery order.
  task automatic check_stream(input string tag);
    bit exp_bits[$];
    int mism = 0;
    foreach (sent_q[k])
      for (int b = 7; b >= 0; b--) exp_bits.push_back(sent_q[k][b]);
    if (exp_bits.size() != rise_bits.size()) mism++;
    for (int k = 0; k < exp_bits.size() && k < rise_bits.size(); k++)
      if (exp_bits[k] != rise_bits[k]) mism++;
    check({tag, "_stream"}, mism, 0);
  endtask

  task automatic check_complete(input string tag);
    check({tag, "_rises"}, rises, NBITS);
    check({tag, "_reads"}, reads, NBYTES);
    check({tag, "_end_cnt"}, end_cnt, 1);
    check({tag, "_end_width"}, end_long, 0);
    check({tag, "_err"}, int'(Out_Err_Timeout), 0);
    check_stream(tag);
  endtask

  initial begin
    logic [7:0] first8;
    int         base, tail;

    Rst_N    = 1'b0;
    Start_In = 1'b0;
    step(3);
    check("reset_outs", int'({Out_Fifo_Rd_En, Out_Clk_Probe, Out_Srin_Probe,
                              Out_Busy, End_Flag, Out_Err_Timeout}), 0);
    Rst_N = 1'b1;
    step(2);
    check("idle_busy", int'(Out_Busy), 0);

    // Known pattern: 0xA5 then zeros.
    fifo_q.push_back(8'hA5);
    repeat (NBYTES - 1) fifo_q.push_back(8'h00);
    clear_mon();
    pulse_start();
    check("start_busy", int'(Out_Busy), 1);
    wait_idle("a5");
    first8 = '0;
    for (int k = 0; k < 8 && k < rise_bits.size(); k++) first8[7-k] = rise_bits[k];
    check("a5_first8", int'(first8), 8'hA5);
    check_complete("a5");
`ifdef PROBE_SROUT_COUNT_EN
    check("srout_ones", int'(Out_Srout_Ones), NBITS);
`endif

    // FIFO runs dry after byte 100, refilled before the timeout.
    clear_mon();
    push_rand(100);
    pulse_start();
    wait_rises(800, "gap");
    base = rises;
    step(15);
    check("gap_rises", rises - base, 0);
    check("gap_busy", int'(Out_Busy), 1);
    push_rand(NBYTES - 100);
    wait_idle("gap");
    check_complete("gap");

    // Only 10 bytes: abort after RD_TIMEOUT stalled cycles.
    clear_mon();
    push_rand(10);
    pulse_start();
    wait_rises(80, "tmo");
    check("tmo_err_early", int'(Out_Err_Timeout), 0);
    tail = 0;
    while (Out_Busy && tail < 200) begin
      step(1);
      tail++;
    end
    check("tmo_tail", tail, (CLK_DIV - 1) + 1 + RD_TIMEOUT + 1);
    check("tmo_rises", rises, 80);
    check("tmo_reads", reads, 10);
    check("tmo_err", int'(Out_Err_Timeout), 1);
    check("tmo_no_end", end_cnt, 0);
    check("tmo_busy", int'(Out_Busy), 0);
    check_stream("tmo");

    // Next start clears the sticky error.
    clear_mon();
    push_rand(NBYTES);
    pulse_start();
    check("recover_err_clr", int'(Out_Err_Timeout), 0);
    wait_idle("recover");
    check_complete("recover");

    // Asynchronous reset in the middle of byte 50.
    clear_mon();
    push_rand(NBYTES);
    pulse_start();
    base = 0;
    while (reads < 50 && base < BUDGET) begin
      step(1);
      base++;
    end
    check("rst_reach", int'(reads >= 50), 1);
    step(7);
    Rst_N = 1'b0;
    #1;
    check("rst_outs", int'({Out_Fifo_Rd_En, Out_Clk_Probe, Out_Srin_Probe,
                            Out_Busy, End_Flag, Out_Err_Timeout}), 0);
    step(2);
    fifo_q.delete();
    Rst_N = 1'b1;
    step(2);
    check("rst_idle", int'(Out_Busy), 0);
    clear_mon();
    push_rand(NBYTES);
    pulse_start();
    wait_idle("after_rst");
    check_complete("after_rst");

    // A second start while busy must be ignored.
    clear_mon();
    push_rand(NBYTES);
    pulse_start();
    step(300);
    pulse_start();
    wait_idle("dbl");
    step(5);
    check("dbl_stays_idle", int'(Out_Busy), 0);
    check_complete("dbl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
